// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares one 2-read/1-write register file between two
// requesters (req0 = core datapath, req1 = debug/loader port).
// At most one request is granted per cycle. Read data returns through a
// one-entry response slot per requester.
// Optional feature macro: ZERO_REG_EN (register 0 hardwired to zero).
module regfile_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addrA,
  input  logic [ADDR_W-1:0] req0_addrB,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_dataA,
  output logic [DATA_W-1:0] rsp0_dataB,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addrA,
  input  logic [ADDR_W-1:0] req1_addrB,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_dataA,
  output logic [DATA_W-1:0] rsp1_dataB,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_readReg1,
  output logic [ADDR_W-1:0] rf_readReg2,
  output logic [ADDR_W-1:0] rf_writeReg,
  output logic [DATA_W-1:0] rf_writeData,
  input  logic [DATA_W-1:0] rf_readData1,
  input  logic [DATA_W-1:0] rf_readData2
);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_PENDING,
    SLOT_FULL
  } slot_t;

  // Requester-indexed views of the two request/response ports
  logic [1:0]        valid;
  logic [1:0]        write;
  logic [1:0]        rsp_ready;
  logic [ADDR_W-1:0] addr_a [2];
  logic [ADDR_W-1:0] addr_b [2];
  logic [DATA_W-1:0] wdata  [2];

  logic [1:0]        eligible;
  logic [1:0]        grant;
  logic [1:0]        accept_read;
  logic              sel;
  logic              last_grant;

  slot_t             slot   [2];
  logic [DATA_W-1:0] data_a [2];
  logic [DATA_W-1:0] data_b [2];
`ifdef ZERO_REG_EN
  logic [1:0]        zero_a;
  logic [1:0]        zero_b;
`endif

  assign valid     = {req1_valid, req0_valid};
  assign write     = {req1_write, req0_write};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign addr_a[0] = req0_addrA;
  assign addr_a[1] = req1_addrA;
  assign addr_b[0] = req0_addrB;
  assign addr_b[1] = req1_addrB;
  assign wdata[0]  = req0_wdata;
  assign wdata[1]  = req1_wdata;

  // A read may only go ahead when its slot is free or is being drained this cycle
  always_comb begin
    eligible = '0;
    for (int i = 0; i < 2; i++) begin
      eligible[i] = valid[i] &&
                    (write[i] || (slot[i] == SLOT_IDLE) ||
                     ((slot[i] == SLOT_FULL) && rsp_ready[i]));
    end
  end

  // Pick one eligible requester; nothing is granted while reset is asserted
  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      if (eligible[0] && eligible[1]) begin
        if (RR_EN && !last_grant) begin
          grant = 2'b10;
        end else begin
          grant = 2'b01;
        end
      end else begin
        grant = eligible;
      end
    end
  end

  assign sel         = grant[1];
  assign accept_read = grant & ~write;
  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];

  // Steer the granted request onto the register-file ports; idle drives zeros
  always_comb begin
    rf_write     = 1'b0;
    rf_readReg1  = '0;
    rf_readReg2  = '0;
    rf_writeReg  = '0;
    rf_writeData = '0;
    if (|grant) begin
      if (write[sel]) begin
`ifdef ZERO_REG_EN
        rf_write = (addr_a[sel] != '0);
`else
        rf_write = 1'b1;
`endif
        rf_writeReg  = addr_a[sel];
        rf_writeData = wdata[sel];
      end else begin
        rf_readReg1 = addr_a[sel];
        rf_readReg2 = addr_b[sel];
      end
    end
  end

  // Round-robin pointer remembers who won last; reset value lets req0 win first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

  // Per-requester response slot: read accepted, data returns one edge later, held until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        slot[i]   <= SLOT_IDLE;
        data_a[i] <= '0;
        data_b[i] <= '0;
      end
`ifdef ZERO_REG_EN
      zero_a <= '0;
      zero_b <= '0;
`endif
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (slot[i])
          SLOT_IDLE: begin
            if (accept_read[i]) slot[i] <= SLOT_PENDING;
          end
          SLOT_PENDING: begin
            slot[i] <= SLOT_FULL;
`ifdef ZERO_REG_EN
            data_a[i] <= zero_a[i] ? '0 : rf_readData1;
            data_b[i] <= zero_b[i] ? '0 : rf_readData2;
`else
            data_a[i] <= rf_readData1;
            data_b[i] <= rf_readData2;
`endif
          end
          SLOT_FULL: begin
            if (accept_read[i]) begin
              slot[i] <= SLOT_PENDING;
            end else if (rsp_ready[i]) begin
              slot[i] <= SLOT_IDLE;
            end
          end
          default: slot[i] <= SLOT_IDLE;
        endcase
`ifdef ZERO_REG_EN
        if (accept_read[i]) begin
          zero_a[i] <= (addr_a[i] == '0);
          zero_b[i] <= (addr_b[i] == '0);
        end
`endif
      end
    end
  end

  assign rsp0_valid = (slot[0] == SLOT_FULL);
  assign rsp1_valid = (slot[1] == SLOT_FULL);
  assign rsp0_dataA = data_a[0];
  assign rsp0_dataB = data_b[0];
  assign rsp1_dataA = data_a[1];
  assign rsp1_dataB = data_b[1];

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed scenarios plus a randomized run checked
// against a behavioural model (shadow register contents, one outstanding
// response per requester, arbitration rules). A second instance built with
// fixed priority is used for the starvation scenario.
`timescale 1ns/1ps
module tb_regfile_arbiter;

`ifdef ZERO_REG_EN
  localparam logic ZERO_EN = 1'b1;
`else
  localparam logic ZERO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [4:0]  req0_addrA, req0_addrB, req1_addrA, req1_addrB;
  logic [31:0] req0_wdata, req1_wdata;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_dataA, rsp0_dataB, rsp1_dataA, rsp1_dataB;
  logic        rf_write;
  logic [4:0]  rf_readReg1, rf_readReg2, rf_writeReg;
  logic [31:0] rf_writeData, rf_readData1, rf_readData2;

  logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
  logic [31:0] fp_rsp0_dataA, fp_rsp0_dataB, fp_rsp1_dataA, fp_rsp1_dataB;
  logic        fp_rf_write;
  logic [4:0]  fp_rf_readReg1, fp_rf_readReg2, fp_rf_writeReg;
  logic [31:0] fp_rf_writeData;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] rf_mem  [32];
  logic [31:0] ref_mem [32];

  always #5 clk = ~clk;

  regfile_arbiter #(.DATA_W(32), .ADDR_W(5), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addrA(req0_addrA), .req0_addrB(req0_addrB), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_dataA(rsp0_dataA), .rsp0_dataB(rsp0_dataB),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addrA(req1_addrA), .req1_addrB(req1_addrB), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_dataA(rsp1_dataA), .rsp1_dataB(rsp1_dataB),
    .rf_write(rf_write), .rf_readReg1(rf_readReg1), .rf_readReg2(rf_readReg2),
    .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData),
    .rf_readData1(rf_readData1), .rf_readData2(rf_readData2)
  );

  regfile_arbiter #(.DATA_W(32), .ADDR_W(5), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_write(req0_write),
    .req0_addrA(req0_addrA), .req0_addrB(req0_addrB), .req0_wdata(req0_wdata),
    .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_dataA(fp_rsp0_dataA), .rsp0_dataB(fp_rsp0_dataB),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_write(req1_write),
    .req1_addrA(req1_addrA), .req1_addrB(req1_addrB), .req1_wdata(req1_wdata),
    .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_dataA(fp_rsp1_dataA), .rsp1_dataB(fp_rsp1_dataB),
    .rf_write(fp_rf_write), .rf_readReg1(fp_rf_readReg1), .rf_readReg2(fp_rf_readReg2),
    .rf_writeReg(fp_rf_writeReg), .rf_writeData(fp_rf_writeData),
    .rf_readData1(32'd0), .rf_readData2(32'd0)
  );

  // Register file: registered reads with one-cycle latency, write on the edge
  always @(posedge clk) begin
    rf_readData1 <= rf_mem[rf_readReg1];
    rf_readData2 <= rf_mem[rf_readReg2];
    if (rf_write) rf_mem[rf_writeReg] <= rf_writeData;
  end

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (ZERO_EN && a == 5'd0) return 32'd0;
    return ref_mem[a];
  endfunction

  function automatic void model_write(input logic [4:0] a, input logic [31:0] d);
    if (ZERO_EN && a == 5'd0) return;
    ref_mem[a] = d;
  endfunction

  task automatic clear_inputs();
    req0_valid = 0; req0_write = 0; req0_addrA = '0; req0_addrB = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addrA = '0; req1_addrB = '0; req1_wdata = '0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    tick();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 rst_n = 0;
    req0_valid = 1; req0_write = 1; req0_addrA = 5'd9; req0_wdata = 32'hA5A5_0001;
    req1_valid = 1; req1_write = 0; req1_addrA = 5'd4;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++; if (req0_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_req0_ready: got %b want 0", req0_ready); end
      tests_run++; if (req1_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_req1_ready: got %b want 0", req1_ready); end
      tests_run++; if (rf_write !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rf_write: got %b want 0", rf_write); end
      tests_run++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_rsp_valid: got %b want 00", {rsp0_valid, rsp1_valid}); end
      tests_run++; if ({rsp0_dataA, rsp1_dataB} !== 64'd0) begin tests_failed++; $display("[TB] FAIL reset_rsp_data: got %h want 0", {rsp0_dataA, rsp1_dataB}); end
    end
    clear_inputs();
    rst_n = 1;
    tick();
  endtask

  task automatic test_write_read();
    logic [31:0] ea, eb;
    do_reset();
    req0_valid = 1; req0_write = 1; req0_addrA = 5'd3; req0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    tests_run++; if (req0_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL wr_ready: got %b want 1", req0_ready); end
    tests_run++; if ({rf_write, rf_writeReg, rf_writeData} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin tests_failed++; $display("[TB] FAIL wr_rf_drive: got %b/%0d/%h want 1/3/deadbeef", rf_write, rf_writeReg, rf_writeData); end
    model_write(5'd3, 32'hDEADBEEF);
    tick();
    req0_write = 0; req0_addrA = 5'd3; req0_addrB = 5'd0;
    @(negedge clk);
    tests_run++; if (req0_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rd_ready: got %b want 1", req0_ready); end
    tests_run++; if ({rf_write, rf_readReg1, rf_readReg2} !== {1'b0, 5'd3, 5'd0}) begin tests_failed++; $display("[TB] FAIL rd_rf_drive: got %b/%0d/%0d want 0/3/0", rf_write, rf_readReg1, rf_readReg2); end
    ea = model_read(5'd3); eb = model_read(5'd0);
    tick();
    req0_valid = 0;
    @(negedge clk);
    tests_run++; if (rsp0_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd_pending_valid: got %b want 0", rsp0_valid); end
    tick();
    @(negedge clk);
    tests_run++; if (rsp0_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rd_rsp_valid: got %b want 1", rsp0_valid); end
    tests_run++; if (rsp0_dataA !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL rd_dataA: got %h want deadbeef", rsp0_dataA); end
    tests_run++; if (rsp0_dataB !== eb) begin tests_failed++; $display("[TB] FAIL rd_dataB: got %h want %h", rsp0_dataB, eb); end
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    @(negedge clk);
    tests_run++; if (rsp0_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd_consumed: got %b want 0", rsp0_valid); end
    if (ea !== 32'hDEADBEEF) $display("[TB] note: model read of reg 3 is %h", ea);
    clear_inputs();
  endtask

  task automatic test_arbitration();
    bit win0;
    do_reset();
    req0_valid = 1; req0_write = 1; req1_valid = 1; req1_write = 1;
    for (int c = 0; c < 6; c++) begin
      req0_addrA = 5'($urandom_range(1, 31)); req0_wdata = $urandom();
      req1_addrA = 5'($urandom_range(1, 31)); req1_wdata = $urandom();
      @(negedge clk);
      win0 = (c % 2 == 0);
      tests_run++; if ({req0_ready, req1_ready} !== {win0, !win0}) begin tests_failed++; $display("[TB] FAIL rr_grant c=%0d: got %b%b want %b%b", c, req0_ready, req1_ready, win0, !win0); end
      tests_run++; if (rf_writeData !== (win0 ? req0_wdata : req1_wdata)) begin tests_failed++; $display("[TB] FAIL rr_wdata c=%0d: got %h want %h", c, rf_writeData, win0 ? req0_wdata : req1_wdata); end
      tests_run++; if ({fp_req0_ready, fp_req1_ready} !== 2'b10) begin tests_failed++; $display("[TB] FAIL fp_grant c=%0d: got %b%b want 10", c, fp_req0_ready, fp_req1_ready); end
      if (win0) model_write(req0_addrA, req0_wdata); else model_write(req1_addrA, req1_wdata);
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] e5a, e5b, e6a, e6b;
    do_reset();
    req1_valid = 1; req1_write = 0; req1_addrA = 5'd5; req1_addrB = 5'd6;
    @(negedge clk);
    tests_run++; if (req1_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_first_ready: got %b want 1", req1_ready); end
    e5a = model_read(5'd5); e5b = model_read(5'd6);
    tick();
    req1_addrA = 5'd6; req1_addrB = 5'd5; rsp1_ready = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests_run++; if (req1_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_stall_ready c=%0d: got %b want 0", c, req1_ready); end
      tests_run++; if (rsp1_valid !== (c > 0)) begin tests_failed++; $display("[TB] FAIL bp_stall_valid c=%0d: got %b want %b", c, rsp1_valid, c > 0); end
      if (c > 0) begin
        tests_run++; if (rsp1_dataA !== e5a) begin tests_failed++; $display("[TB] FAIL bp_hold_dataA c=%0d: got %h want %h", c, rsp1_dataA, e5a); end
      end
      tick();
    end
    rsp1_ready = 1;
    @(negedge clk);
    tests_run++; if (req1_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_release_ready: got %b want 1", req1_ready); end
    tests_run++; if ({rsp1_valid, rsp1_dataA, rsp1_dataB} !== {1'b1, e5a, e5b}) begin tests_failed++; $display("[TB] FAIL bp_first_rsp: got %b/%h/%h want 1/%h/%h", rsp1_valid, rsp1_dataA, rsp1_dataB, e5a, e5b); end
    e6a = model_read(5'd6); e6b = model_read(5'd5);
    tick();
    req1_valid = 0; rsp1_ready = 0;
    @(negedge clk);
    tests_run++; if (rsp1_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_second_pending: got %b want 0", rsp1_valid); end
    tick();
    @(negedge clk);
    tests_run++; if ({rsp1_valid, rsp1_dataA, rsp1_dataB} !== {1'b1, e6a, e6b}) begin tests_failed++; $display("[TB] FAIL bp_second_rsp: got %b/%h/%h want 1/%h/%h", rsp1_valid, rsp1_dataA, rsp1_dataB, e6a, e6b); end
    rsp1_ready = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_contention_rw();
    logic [31:0] eb;
    do_reset();
    req0_valid = 1; req0_write = 1; req0_addrA = 5'd7; req0_wdata = 32'h11;
    req1_valid = 1; req1_write = 0; req1_addrA = 5'd7; req1_addrB = 5'd2;
    @(negedge clk);
    tests_run++; if ({req0_ready, req1_ready} !== 2'b10) begin tests_failed++; $display("[TB] FAIL crw_first_grant: got %b%b want 10", req0_ready, req1_ready); end
    tests_run++; if ({rf_write, rf_writeReg} !== {1'b1, 5'd7}) begin tests_failed++; $display("[TB] FAIL crw_write_drive: got %b/%0d want 1/7", rf_write, rf_writeReg); end
    model_write(5'd7, 32'h11);
    tick();
    req0_valid = 0;
    @(negedge clk);
    tests_run++; if ({req1_ready, rf_readReg1} !== {1'b1, 5'd7}) begin tests_failed++; $display("[TB] FAIL crw_read_grant: got %b/%0d want 1/7", req1_ready, rf_readReg1); end
    eb = model_read(5'd2);
    tick();
    req1_valid = 0;
    tick();
    @(negedge clk);
    tests_run++; if ({rsp1_valid, rsp1_dataA, rsp1_dataB} !== {1'b1, 32'h11, eb}) begin tests_failed++; $display("[TB] FAIL crw_rsp: got %b/%h/%h want 1/00000011/%h", rsp1_valid, rsp1_dataA, rsp1_dataB, eb); end
    rsp1_ready = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req0_valid = 1; req0_write = 0; req0_addrA = 5'd10; req0_addrB = 5'd11;
    @(negedge clk);
    tests_run++; if (req0_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_accept: got %b want 1", req0_ready); end
    tick();
    rst_n = 0;
    req1_valid = 1; req1_write = 1; req1_addrA = 5'd12; req1_wdata = $urandom();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++; if ({req0_ready, req1_ready, rf_write, rsp0_valid} !== 4'b0000) begin tests_failed++; $display("[TB] FAIL mid_in_reset c=%0d: got %b want 0000", c, {req0_ready, req1_ready, rf_write, rsp0_valid}); end
      tick();
    end
    clear_inputs();
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++; if ({rsp0_valid, rsp0_dataA} !== 33'd0) begin tests_failed++; $display("[TB] FAIL mid_no_stale c=%0d: got %b/%h want 0/0", c, rsp0_valid, rsp0_dataA); end
      tick();
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] eb;
    do_reset();
    req0_valid = 1; req0_write = 1; req0_addrA = 5'd0; req0_wdata = 32'h55;
    @(negedge clk);
    tests_run++; if (req0_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero_wr_ready: got %b want 1", req0_ready); end
    tests_run++; if (rf_write !== !ZERO_EN) begin tests_failed++; $display("[TB] FAIL zero_wr_rf_write: got %b want %b", rf_write, !ZERO_EN); end
    model_write(5'd0, 32'h55);
    tick();
    req0_write = 0; req0_addrA = 5'd0; req0_addrB = 5'd3;
    eb = model_read(5'd3);
    tick();
    req0_valid = 0;
    tick();
    @(negedge clk);
    tests_run++; if (rsp0_dataA !== (ZERO_EN ? 32'd0 : 32'h55)) begin tests_failed++; $display("[TB] FAIL zero_rd_dataA: got %h want %h", rsp0_dataA, ZERO_EN ? 32'd0 : 32'h55); end
    tests_run++; if ({rsp0_valid, rsp0_dataB} !== {1'b1, eb}) begin tests_failed++; $display("[TB] FAIL zero_rd_dataB: got %b/%h want 1/%h", rsp0_valid, rsp0_dataB, eb); end
    rsp0_ready = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    bit outstanding [2];
    bit acc_prev [2];
    bit full [2];
    bit elig [2];
    bit v [2], w [2], rdy [2], rr [2], rv [2];
    logic [4:0]  a [2], b [2];
    logic [31:0] d [2], da [2], db [2];
    logic [63:0] pend [2];
    bit last_win, exp_rfw;
    int g;
    do_reset();
    for (int i = 0; i < 2; i++) begin outstanding[i] = 0; acc_prev[i] = 0; pend[i] = '0; end
    last_win = 1;
    for (int c = 0; c < 400; c++) begin
      req0_valid = ($urandom_range(0, 9) < 7); req0_write = ($urandom_range(0, 2) == 0);
      req0_addrA = 5'($urandom_range(0, 31)); req0_addrB = 5'($urandom_range(0, 31)); req0_wdata = $urandom();
      req1_valid = ($urandom_range(0, 9) < 7); req1_write = ($urandom_range(0, 2) == 0);
      req1_addrA = 5'($urandom_range(0, 31)); req1_addrB = 5'($urandom_range(0, 31)); req1_wdata = $urandom();
      rsp0_ready = 1'($urandom_range(0, 1)); rsp1_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      v[0] = req0_valid; w[0] = req0_write; a[0] = req0_addrA; b[0] = req0_addrB; d[0] = req0_wdata;
      v[1] = req1_valid; w[1] = req1_write; a[1] = req1_addrA; b[1] = req1_addrB; d[1] = req1_wdata;
      rdy[0] = req0_ready; rr[0] = rsp0_ready; rv[0] = rsp0_valid; da[0] = rsp0_dataA; db[0] = rsp0_dataB;
      rdy[1] = req1_ready; rr[1] = rsp1_ready; rv[1] = rsp1_valid; da[1] = rsp1_dataA; db[1] = rsp1_dataB;
      for (int i = 0; i < 2; i++) begin
        full[i] = outstanding[i] && !acc_prev[i];
        elig[i] = v[i] && (w[i] || !outstanding[i] || (full[i] && rr[i]));
        tests_run++; if (rv[i] !== full[i]) begin tests_failed++; $display("[TB] FAIL rand_rsp_valid c=%0d r=%0d: got %b want %b", c, i, rv[i], full[i]); end
        if (full[i] && rr[i]) begin
          tests_run++; if ({da[i], db[i]} !== pend[i]) begin tests_failed++; $display("[TB] FAIL rand_rsp_data c=%0d r=%0d: got %h want %h", c, i, {da[i], db[i]}, pend[i]); end
          outstanding[i] = 0;
        end
      end
      tests_run++; if ((rdy[0] | rdy[1]) !== (elig[0] | elig[1])) begin tests_failed++; $display("[TB] FAIL rand_work_conserve c=%0d: got %b%b elig %b%b", c, rdy[0], rdy[1], elig[0], elig[1]); end
      tests_run++; if ((rdy[0] && rdy[1]) || (rdy[0] && !elig[0]) || (rdy[1] && !elig[1])) begin tests_failed++; $display("[TB] FAIL rand_grant_legal c=%0d: got %b%b elig %b%b", c, rdy[0], rdy[1], elig[0], elig[1]); end
      if (elig[0] && elig[1]) begin
        tests_run++; if (rdy[last_win ? 0 : 1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL rand_rr_order c=%0d: got %b%b want winner %0d", c, rdy[0], rdy[1], last_win ? 0 : 1); end
      end
      g = rdy[1] ? 1 : 0;
      if (rdy[0] || rdy[1]) begin
        last_win = rdy[1];
        if (w[g]) begin
          exp_rfw = !(ZERO_EN && a[g] == 5'd0);
          tests_run++; if (rf_write !== exp_rfw) begin tests_failed++; $display("[TB] FAIL rand_rf_write c=%0d: got %b want %b", c, rf_write, exp_rfw); end
          if (exp_rfw) begin
            tests_run++; if ({rf_writeReg, rf_writeData} !== {a[g], d[g]}) begin tests_failed++; $display("[TB] FAIL rand_rf_wdrive c=%0d: got %0d/%h want %0d/%h", c, rf_writeReg, rf_writeData, a[g], d[g]); end
          end
          model_write(a[g], d[g]);
        end else begin
          tests_run++; if ({rf_write, rf_readReg1, rf_readReg2} !== {1'b0, a[g], b[g]}) begin tests_failed++; $display("[TB] FAIL rand_rf_rdrive c=%0d: got %b/%0d/%0d want 0/%0d/%0d", c, rf_write, rf_readReg1, rf_readReg2, a[g], b[g]); end
          outstanding[g] = 1;
          pend[g] = {model_read(a[g]), model_read(b[g])};
        end
      end else begin
        tests_run++; if ({rf_write, rf_readReg1, rf_readReg2, rf_writeReg, rf_writeData} !== 48'd0) begin tests_failed++; $display("[TB] FAIL rand_rf_idle c=%0d: rf outputs not zero", c); end
      end
      for (int i = 0; i < 2; i++) acc_prev[i] = rdy[i] && !w[i];
      tick();
    end
    clear_inputs();
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (3) tick();
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < 32; k++) begin
      rf_mem[k]  = $urandom();
      ref_mem[k] = rf_mem[k];
    end
    rf_mem[0]  = ZERO_EN ? 32'hBAD0_0BAD : 32'd0;
    ref_mem[0] = 32'd0;
    clear_inputs();
    test_reset();
    test_write_read();
    test_arbitration();
    test_back_to_back();
    test_contention_rw();
    test_reset_midflight();
    test_zero_reg();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
